tft_frame_sequencer: RTL and testbench
======================================

Name: tft_frame_sequencer

Overview:
- Upstream feeder for the TFT SPI serializer.
- Drives the panel hardware reset, streams a fixed controller init sequence, sets the full-screen address window, then streams WIDTH*HEIGHT 16-bit pixels of one colour.
- The colour comes from the 16-bit switch bus.
- Repaints automatically whenever the colour input changes; hands out one command/data item at a time over a valid/ready handshake.

Parameters:
- WIDTH, 128, panel columns; 1..256.
- HEIGHT, 160, panel rows; 1..256.
- RST_CYCLES, 1000, MasterCLK cycles TFT_RST is held low.
- DELAY_CYCLES, 12000000, MasterCLK cycles waited after the reset release, after SWRESET and after SLPOUT.

Ports:
- MasterCLK  in  1  system clock; all logic on its rising edge.
- MasterRST_n  in  1  asynchronous active-low reset.
- color  in  16  RGB565 fill colour (switches); asynchronous, double-flop synchronised internally.
- out_valid  out  1  out_data/out_rs/out_wide hold a valid item.
- out_ready  in  1  serializer accepts the item this cycle.
- out_data  out  16  item payload; bytes in [7:0] with [15:8]=0.
- out_rs  out  1  0=command, 1=data (maps to RS).
- out_wide  out  1  1=16-bit pixel word, 0=8-bit byte.
- tft_rst  out  1  panel reset, active low.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async assert, sync deassert through a 2-flop synchroniser on MasterRST_n): state=RST_LOW, out_valid=0, out_data=0, out_rs=0, out_wide=0, tft_rst=0, busy=1, counters=0, latched colour=0.
- Handshake:
  - Item transfers on a cycle with out_valid&out_ready.
  - While out_valid=1 and out_ready=0, all out_* are held stable.
  - The next item may be presented the cycle after a transfer, giving 1 item/cycle maximum throughput.
  - out_valid is never deasserted without a transfer, except by reset.
- States:
  - RST_LOW: tft_rst=0 for RST_CYCLES cycles -> RST_WAIT.
  - RST_WAIT: tft_rst=1, wait DELAY_CYCLES -> INIT.
  - INIT: walk an 8-entry ROM, emitting bytes (out_wide=0):
    - cmd 0x01 (SWRESET), then delay;
    - cmd 0x11 (SLPOUT), then delay;
    - cmd 0x3A, data 0x05 (COLMOD 16bpp);
    - cmd 0x29 (DISPON).
    - Delay entries emit nothing and count DELAY_CYCLES with out_valid=0.
    - After the last transfer -> LATCH.
  - LATCH: capture the synchronised colour into the frame register (1 cycle) -> WIN.
  - WIN: emit in order:
    - cmd 0x2A, data 0x00, 0x00, 0x00, WIDTH-1;
    - cmd 0x2B, data 0x00, 0x00, 0x00, HEIGHT-1;
    - cmd 0x2C.
    - -> FILL.
  - FILL: emit WIDTH*HEIGHT items with out_rs=1, out_wide=1, out_data=frame colour.
    - The pixel counter is 16 bits; the final pixel is at count WIDTH*HEIGHT-1.
    - After the final transfer -> IDLE.
  - IDLE: busy=0, out_valid=0. When the synchronised colour != frame colour -> LATCH.
- Colour changes during WIN/FILL never alter the frame in progress; the current frame completes with the old colour, and IDLE then detects the difference on its first cycle.
- Simultaneous events: the last pixel transfer and a colour change in the same cycle -> IDLE, then LATCH on the next cycle.
- Mid-operation reset: all outputs return to reset values immediately (asynchronously), and the sequence restarts at RST_LOW. The partial item is abandoned.
- Delay and reset counters are sized by $clog2 of their parameter. Counters wrap only by explicit reload to 0 on state entry.

Test Plan:
- Reset with RST_CYCLES=4, DELAY_CYCLES=8, out_ready=1:
  - tft_rst low for exactly 4 cycles after release, then high.
  - First item 0x01/rs=0 appears at least 8 cycles later.
  - No out_valid during any delay.
- Full stream with WIDTH=4, HEIGHT=3, color=0xF800:
  - Exact item sequence 01,11,3A,05,29,2A,00,00,00,03,2B,00,00,00,02,2C.
  - Then exactly 12 items of 0xF800 with rs=1, wide=1.
  - busy falls the cycle after the 12th transfer.
- Backpressure: random out_ready (50%) during WIN/FILL:
  - out_* stable while stalled.
  - Item sequence and count identical to the previous scenario.
- Colour change 0xF800->0x001F mid-FILL:
  - Remaining pixels stay 0xF800.
  - After IDLE, a second WIN+FILL follows with 12 pixels of 0x001F.
- MasterRST_n pulsed low during FILL pixel 5:
  - Outputs reset within the same cycle (asynchronous).
  - After release, tft_rst=0 again and the stream restarts from SWRESET.
- Colour unchanged in IDLE for 100 cycles: no out_valid, busy stays 0.

Source files
------------

// File: rtl/tft_frame_sequencer.sv
// tft_frame_sequencer: panel reset, controller init, address window and a
// single-colour full-screen fill, handed to the SPI serializer item by item.
module tft_frame_sequencer #(
  parameter int WIDTH        = 128,
  parameter int HEIGHT       = 160,
  parameter int RST_CYCLES   = 1000,
  parameter int DELAY_CYCLES = 12000000
) (
  input  logic        MasterCLK,
  input  logic        MasterRST_n,
  input  logic [15:0] color,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_rs,
  output logic        out_wide,
  output logic        tft_rst,
  output logic        busy
);

  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int DCW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;

  localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);
  localparam logic [DCW-1:0] DLY_LAST = DCW'(DELAY_CYCLES - 1);
  localparam logic [15:0]    PIX_LAST = 16'(WIDTH * HEIGHT - 1);
  localparam logic [7:0]     COL_LAST = 8'(WIDTH - 1);
  localparam logic [7:0]     ROW_LAST = 8'(HEIGHT - 1);
  localparam logic [3:0]     WIN_END  = 4'd11;

  typedef enum logic [2:0] {
    S_RST_LOW,
    S_RST_WAIT,
    S_INIT,
    S_LATCH,
    S_WIN,
    S_FILL,
    S_IDLE
  } state_t;

  typedef enum logic [1:0] {
    K_CMD,
    K_DAT,
    K_DLY,
    K_END
  } kind_t;

  function automatic logic [9:0] init_rom(input logic [2:0] a);
    logic [9:0] r;
    case (a)
      3'd0:    r = {K_CMD, 8'h01};
      3'd1:    r = {K_DLY, 8'h00};
      3'd2:    r = {K_CMD, 8'h11};
      3'd3:    r = {K_DLY, 8'h00};
      3'd4:    r = {K_CMD, 8'h3A};
      3'd5:    r = {K_DAT, 8'h05};
      3'd6:    r = {K_CMD, 8'h29};
      default: r = {K_END, 8'h00};
    endcase
    return r;
  endfunction

  // {rs, byte}; column then row window, then memory write
  function automatic logic [8:0] win_rom(input logic [3:0] a);
    logic [8:0] r;
    case (a)
      4'd0:    r = {1'b0, 8'h2A};
      4'd4:    r = {1'b1, COL_LAST};
      4'd5:    r = {1'b0, 8'h2B};
      4'd9:    r = {1'b1, ROW_LAST};
      4'd10:   r = {1'b0, 8'h2C};
      default: r = {1'b1, 8'h00};
    endcase
    return r;
  endfunction

  logic [1:0] rsync_q;
  logic       rst_n;

  always_ff @(posedge MasterCLK or negedge MasterRST_n) begin
    if (!MasterRST_n) rsync_q <= 2'b00;
    else              rsync_q <= {rsync_q[0], 1'b1};
  end

  assign rst_n = rsync_q[1];

  logic [15:0]    csync1_q, csync2_q;
  state_t         state_q, state_d;
  logic [RCW-1:0] rcnt_q, rcnt_d;
  logic [DCW-1:0] dcnt_q, dcnt_d;
  logic [3:0]     idx_q, idx_d;
  logic [15:0]    pix_q, pix_d;
  logic [15:0]    frame_q, frame_d;
  logic           valid_q, valid_d;
  logic [15:0]    data_q, data_d;
  logic           rs_q, rs_d;
  logic           wide_q, wide_d;
  logic           trst_q, trst_d;

  logic [9:0] irom;
  logic [8:0] wrom;
  kind_t      ikind;
  logic       xfer;
  logic       free;

  assign irom  = init_rom(idx_q[2:0]);
  assign wrom  = win_rom(idx_q);
  assign ikind = kind_t'(irom[9:8]);
  assign xfer  = valid_q & out_ready;
  assign free  = ~valid_q | xfer;

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    dcnt_d  = dcnt_q;
    idx_d   = idx_q;
    pix_d   = pix_q;
    frame_d = frame_q;
    valid_d = valid_q & ~xfer;
    data_d  = data_q;
    rs_d    = rs_q;
    wide_d  = wide_q;
    trst_d  = trst_q;
    case (state_q)
      S_RST_LOW: begin
        trst_d = 1'b0;
        if (rcnt_q == RST_LAST) begin
          state_d = S_RST_WAIT;
          rcnt_d  = '0;
          dcnt_d  = '0;
          trst_d  = 1'b1;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      S_RST_WAIT: begin
        if (dcnt_q == DLY_LAST) begin
          state_d = S_INIT;
          dcnt_d  = '0;
          idx_d   = '0;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      S_INIT: begin
        // delay entries only start once the preceding command has left
        if (free) begin
          case (ikind)
            K_CMD, K_DAT: begin
              valid_d = 1'b1;
              data_d  = {8'h00, irom[7:0]};
              rs_d    = (ikind == K_DAT);
              wide_d  = 1'b0;
              idx_d   = idx_q + 4'd1;
            end
            K_DLY: begin
              if (dcnt_q == DLY_LAST) begin
                dcnt_d = '0;
                idx_d  = idx_q + 4'd1;
              end else begin
                dcnt_d = dcnt_q + 1'b1;
              end
            end
            default: state_d = S_LATCH;
          endcase
        end
      end
      S_LATCH: begin
        frame_d = csync2_q;
        idx_d   = '0;
        state_d = S_WIN;
      end
      S_WIN: begin
        if (free) begin
          valid_d = 1'b1;
          if (idx_q == WIN_END) begin
            data_d  = frame_q;
            rs_d    = 1'b1;
            wide_d  = 1'b1;
            pix_d   = '0;
            state_d = S_FILL;
          end else begin
            data_d = {8'h00, wrom[7:0]};
            rs_d   = wrom[8];
            wide_d = 1'b0;
            idx_d  = idx_q + 4'd1;
          end
        end
      end
      S_FILL: begin
        // payload stays put; each transfer just re-arms valid
        if (xfer) begin
          if (pix_q == PIX_LAST) begin
            state_d = S_IDLE;
          end else begin
            pix_d   = pix_q + 16'd1;
            valid_d = 1'b1;
          end
        end
      end
      S_IDLE: begin
        if (csync2_q != frame_q) state_d = S_LATCH;
      end
      default: state_d = S_RST_LOW;
    endcase
  end

  always_ff @(posedge MasterCLK or negedge rst_n) begin
    if (!rst_n) begin
      csync1_q <= '0;
      csync2_q <= '0;
      state_q  <= S_RST_LOW;
      rcnt_q   <= '0;
      dcnt_q   <= '0;
      idx_q    <= '0;
      pix_q    <= '0;
      frame_q  <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      rs_q     <= 1'b0;
      wide_q   <= 1'b0;
      trst_q   <= 1'b0;
    end else begin
      csync1_q <= color;
      csync2_q <= csync1_q;
      state_q  <= state_d;
      rcnt_q   <= rcnt_d;
      dcnt_q   <= dcnt_d;
      idx_q    <= idx_d;
      pix_q    <= pix_d;
      frame_q  <= frame_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      rs_q     <= rs_d;
      wide_q   <= wide_d;
      trst_q   <= trst_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_rs    = rs_q;
  assign out_wide  = wide_q;
  assign tft_rst   = trst_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_tft_frame_sequencer.sv
// tb_tft_frame_sequencer: directed stream, backpressure, repaint and
// mid-fill reset checks on a 4x3 panel with short delays.
module tb_tft_frame_sequencer;

  localparam int W   = 4;
  localparam int H   = 3;
  localparam int RST = 4;
  localparam int DLY = 8;

  logic        clk = 1'b0;
  logic        MasterRST_n;
  logic [15:0] color;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_rs;
  logic        out_wide;
  logic        tft_rst;
  logic        busy;

  tft_frame_sequencer #(
    .WIDTH(W),
    .HEIGHT(H),
    .RST_CYCLES(RST),
    .DELAY_CYCLES(DLY)
  ) dut (
    .MasterCLK(clk),
    .MasterRST_n(MasterRST_n),
    .color(color),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_rs(out_rs),
    .out_wide(out_wide),
    .tft_rst(tft_rst),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // transfers seen: {wide, rs, data} and the cycle they were offered on
  logic [17:0] q[$];
  int          qc[$];
  logic [17:0] ex[$];

  int          cyc = 0;
  int          fall_cyc = -1;
  int          n_stall = 0;
  bit          rdy_rand = 1'b0;
  logic        pv = 1'b0;
  logic        pr = 1'b0;
  logic        pbusy = 1'b1;
  logic [18:0] psnap = '0;

  initial begin
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!MasterRST_n) begin
        pv = 1'b0;
      end else if (pv && !pr) begin
        n_stall++;
        chk("stall", {out_valid, out_wide, out_rs, out_data}, psnap);
      end
      if (MasterRST_n && pbusy && !busy) fall_cyc = cyc;
      pbusy = busy;
      out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (MasterRST_n && out_valid && out_ready) begin
        q.push_back({out_wide, out_rs, out_data});
        qc.push_back(cyc);
      end
      if (MasterRST_n) begin
        pv    = out_valid;
        pr    = out_ready;
        psnap = {out_valid, out_wide, out_rs, out_data};
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clr();
    q.delete();
    qc.delete();
    ex.delete();
  endtask

  task automatic e_cmd(input logic [7:0] b);
    ex.push_back({1'b0, 1'b0, 8'h00, b});
  endtask

  task automatic e_dat(input logic [7:0] b);
    ex.push_back({1'b0, 1'b1, 8'h00, b});
  endtask

  task automatic e_init();
    e_cmd(8'h01);
    e_cmd(8'h11);
    e_cmd(8'h3A);
    e_dat(8'h05);
    e_cmd(8'h29);
  endtask

  task automatic e_win();
    e_cmd(8'h2A);
    e_dat(8'h00); e_dat(8'h00); e_dat(8'h00); e_dat(8'h03);
    e_cmd(8'h2B);
    e_dat(8'h00); e_dat(8'h00); e_dat(8'h00); e_dat(8'h02);
    e_cmd(8'h2C);
  endtask

  task automatic e_pix(input logic [15:0] c, input int n);
    for (int i = 0; i < n; i++) ex.push_back({1'b1, 1'b1, c});
  endtask

  function automatic int npix();
    int n = 0;
    foreach (q[i]) if (q[i][17]) n++;
    return n;
  endfunction

  task automatic cmp_q(input string tag);
    chk({tag, "_len"}, q.size(), ex.size());
    for (int i = 0; i < ex.size(); i++)
      if (i < q.size())
        chk($sformatf("%s[%0d]", tag, i), q[i], ex[i]);
  endtask

  task automatic wait_done(input string tag, input int need,
                           input int lim);
    int n = 0;
    while (!(q.size() >= need && !busy) && n < lim) begin
      tick();
      n++;
    end
    chk(tag, (n < lim), 1);
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_valid"}, out_valid, 1'b0);
    chk({tag, "_data"}, out_data, 16'h0000);
    chk({tag, "_rs"}, out_rs, 1'b0);
    chk({tag, "_wide"}, out_wide, 1'b0);
    chk({tag, "_tft"}, tft_rst, 1'b0);
    chk({tag, "_busy"}, busy, 1'b1);
  endtask

  initial begin
    int n;
    int nv;
    int nb;
    MasterRST_n = 1'b0;
    color = 16'hF800;
    repeat (3) tick();
    chk_rst("rst");

    @(negedge clk);
    MasterRST_n = 1'b1;
    n = 0;
    tick();
    while (tft_rst === 1'b0 && n < 50) begin
      n++;
      tick();
    end
    // one extra low sample while release ripples through the synchroniser
    chk("tft_low_len", n, RST + 1);
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    chk("rel_gap", n, DLY + 1);
    chk("first_data", out_data, 16'h0001);
    chk("first_rs", out_rs, 1'b0);

    wait_done("s1_done", 28, 400);
    e_init();
    e_win();
    e_pix(16'hF800, 12);
    cmp_q("s1");
    if (q.size() >= 28) begin
      chk("swreset_gap", qc[1] - qc[0], DLY + 1);
      chk("slpout_gap", qc[2] - qc[1], DLY + 1);
      chk("busy_fall", fall_cyc, qc[27] + 1);
    end

    clr();
    rdy_rand = 1'b1;
    color = 16'h07E0;
    wait_done("bp_done", 23, 800);
    e_win();
    e_pix(16'h07E0, 12);
    cmp_q("bp");
    chk("bp_stalled", (n_stall > 0), 1);
    rdy_rand = 1'b0;

    clr();
    color = 16'hF800;
    n = 0;
    while (npix() < 3 && n < 200) begin
      tick();
      n++;
    end
    chk("cc_fill_seen", (n < 200), 1);
    color = 16'h001F;
    wait_done("cc_done", 46, 800);
    e_win();
    e_pix(16'hF800, 12);
    e_win();
    e_pix(16'h001F, 12);
    cmp_q("cc");

    clr();
    color = 16'h1234;
    n = 0;
    while (npix() < 5 && n < 200) begin
      tick();
      n++;
    end
    chk("rr_fill_seen", (n < 200), 1);
    #1;
    MasterRST_n = 1'b0;
    #1;
    chk_rst("rr_async");
    tick();
    tick();
    MasterRST_n = 1'b1;
    clr();
    tick();
    chk("rr_tft_low", tft_rst, 1'b0);
    wait_done("rr_done", 28, 800);
    e_init();
    e_win();
    e_pix(16'h1234, 12);
    cmp_q("rr");

    nv = 0;
    nb = 0;
    repeat (100) begin
      tick();
      if (out_valid) nv++;
      if (busy) nb++;
    end
    chk("idle_valid", nv, 0);
    chk("idle_busy", nb, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
